// File: rtl/rsa_modexp_arbiter.sv
// Round-robin arbiter sharing one modular-exponentiation engine between ch0 (encrypt) and ch1 (decrypt).
// Optional WAIT watchdog enabled by defining RSA_ARB_TIMEOUT_EN.
module rsa_modexp_arbiter #(
    parameter int unsigned WIDTH          = 128,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] msg0,
    input  logic [WIDTH-1:0] msg1,
    input  logic [WIDTH-1:0] key0,
    input  logic [WIDTH-1:0] key1,
    input  logic [WIDTH-1:0] n0,
    input  logic [WIDTH-1:0] n1,
    output logic             ack0,
    output logic             ack1,
    output logic             rsp_valid0,
    output logic             rsp_valid1,
    output logic [WIDTH-1:0] rsp_data0,
    output logic [WIDTH-1:0] rsp_data1,
    output logic             eng_reset,
    output logic             eng_start,
    output logic [WIDTH-1:0] eng_message,
    output logic [WIDTH-1:0] eng_key,
    output logic [WIDTH-1:0] eng_n,
    input  logic             eng_done,
    input  logic [WIDTH-1:0] eng_result,
    output logic             busy,
    output logic             grant_id,
    output logic             timeout_err
);

    typedef enum logic [2:0] {IDLE, ENG_RST, LAUNCH, WAIT, RESP} state_t;

    state_t state, state_next;
    logic   win;
    logic   timeout_hit;

    always_comb begin
        state_next = state;
        // Tie goes to the channel that was not granted last.
        win        = (req0 && req1) ? ~grant_id : ~req0;
        case (state)
            IDLE:    if (req0 || req1) state_next = ENG_RST;
            ENG_RST: state_next = LAUNCH;
            LAUNCH:  state_next = WAIT;
            WAIT:    if (eng_done || timeout_hit) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            grant_id    <= 1'b1;
            rsp_data0   <= '0;
            rsp_data1   <= '0;
            eng_message <= '0;
            eng_key     <= '0;
            eng_n       <= '0;
        end else begin
            state <= state_next;
            ack0  <= 1'b0;
            ack1  <= 1'b0;
            if (state == IDLE && (req0 || req1)) begin
                grant_id    <= win;
                ack0        <= ~win;
                ack1        <= win;
                eng_message <= win ? msg1 : msg0;
                eng_key     <= win ? key1 : key0;
                eng_n       <= win ? n1 : n0;
            end
            if (state == WAIT) begin
                if (eng_done) begin
                    if (grant_id) rsp_data1 <= eng_result;
                    else          rsp_data0 <= eng_result;
                end else if (timeout_hit) begin
                    if (grant_id) rsp_data1 <= '0;
                    else          rsp_data0 <= '0;
                end
            end
        end
    end

    // Pulses are gated by reset so an aborted job never leaks a start or response.
    assign busy       = (state != IDLE) && !reset;
    assign eng_reset  = reset || (state == ENG_RST);
    assign eng_start  = (state == LAUNCH) && !reset;
    assign rsp_valid0 = (state == RESP) && !grant_id && !reset;
    assign rsp_valid1 = (state == RESP) && grant_id && !reset;

`ifdef RSA_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wd_cnt;
    logic        to_flag;

    assign timeout_hit = (state == WAIT) && !eng_done && (wd_cnt == TO_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            wd_cnt  <= '0;
            to_flag <= 1'b0;
        end else begin
            to_flag <= timeout_hit;
            if (state == LAUNCH)    wd_cnt <= '0;
            else if (state == WAIT) wd_cnt <= wd_cnt + 16'd1;
        end
    end

    assign timeout_err = to_flag && !reset;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout_hit    = 1'b0;
    assign timeout_err    = 1'b0;
`endif

endmodule

// File: tb/tb_rsa_modexp_arbiter.sv
// Directed bench for rsa_modexp_arbiter with a behavioural exponentiation engine model.
// Define RSA_ARB_TIMEOUT_EN for both files to also exercise the watchdog.
module tb_rsa_modexp_arbiter;

    localparam int unsigned W = 128;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0] msg0 = '0, msg1 = '0, key0 = '0, key1 = '0, n0 = '0, n1 = '0;
    logic         ack0, ack1, rsp_valid0, rsp_valid1;
    logic [W-1:0] rsp_data0, rsp_data1;
    logic         eng_reset, eng_start, busy, grant_id, timeout_err;
    logic [W-1:0] eng_message, eng_key, eng_n;
    logic         eng_done = 1'b0;
    logic [W-1:0] eng_result = '0;

    int n_vec  = 0;
    int n_miss = 0;
    int n_ack0 = 0, n_ack1 = 0, n_rsp0 = 0, n_rsp1 = 0;

    // Engine model
    int unsigned eng_lat  = 40;
    int unsigned eng_cnt  = 0;
    bit          eng_run  = 1'b0;
    bit          eng_hang = 1'b0;

    rsa_modexp_arbiter #(.WIDTH(W), .TIMEOUT_CYCLES(16)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1),
        .msg0(msg0), .msg1(msg1), .key0(key0), .key1(key1), .n0(n0), .n1(n1),
        .ack0(ack0), .ack1(ack1),
        .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
        .rsp_data0(rsp_data0), .rsp_data1(rsp_data1),
        .eng_reset(eng_reset), .eng_start(eng_start),
        .eng_message(eng_message), .eng_key(eng_key), .eng_n(eng_n),
        .eng_done(eng_done), .eng_result(eng_result),
        .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    function automatic logic [W-1:0] modexp(input logic [W-1:0] b, input logic [W-1:0] e,
                                            input logic [W-1:0] m);
        longint unsigned r, base, mm;
        if (m == '0) return '0;
        mm   = longint'(m[63:0]);
        r    = 1 % mm;
        base = longint'(b[63:0]) % mm;
        for (int i = 0; i < 64; i++) begin
            if (e[i]) r = (r * base) % mm;
            base = (base * base) % mm;
        end
        return W'(r);
    endfunction

    // Done is a level that only an engine reset clears, so it goes stale between jobs.
    always @(posedge clock) begin
        if (eng_reset) begin
            eng_done <= 1'b0;
            eng_run  <= 1'b0;
        end else if (eng_start) begin
            eng_run <= !eng_hang;
            eng_cnt <= eng_lat - 1;
        end else if (eng_run) begin
            if (eng_cnt == 0) begin
                eng_done   <= 1'b1;
                eng_result <= modexp(eng_message, eng_key, eng_n);
                eng_run    <= 1'b0;
            end else begin
                eng_cnt <= eng_cnt - 1;
            end
        end
    end

    always @(negedge clock) begin
        if (ack0)       n_ack0++;
        if (ack1)       n_ack1++;
        if (rsp_valid0) n_rsp0++;
        if (rsp_valid1) n_rsp1++;
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Full single-channel-0 job with cycle-exact overhead checks; DUT must be IDLE on entry.
    task automatic job0(input logic [W-1:0] m, input logic [W-1:0] k, input logic [W-1:0] n,
                        input logic [W-1:0] exp);
        int i;
        req0 = 1'b1; msg0 = m; key0 = k; n0 = n;
        tick();
        check("ack0_at_p1", W'(ack0), 1);
        check("eng_reset_at_p1", W'(eng_reset), 1);
        check("eng_start_at_p1", W'(eng_start), 0);
        check("eng_message", eng_message, m);
        check("eng_key", eng_key, k);
        check("eng_n", eng_n, n);
        check("grant_id_0", W'(grant_id), 0);
        req0 = 1'b0;
        tick();
        check("eng_start_at_p2", W'(eng_start), 1);
        check("ack0_single_pulse", W'(ack0), 0);
        check("done_cleared_p2", W'(eng_done), 0);
        i = 0;
        while (!eng_done && i < 300) begin tick(); i++; end
        check("done_seen", W'(eng_done), 1);
        check("no_early_rsp", W'(rsp_valid0), 0);
        tick();
        check("rsp_valid0", W'(rsp_valid0), 1);
        check("rsp_data0", rsp_data0, exp);
        check("timeout_err_idle", W'(timeout_err), 0);
        tick();
        check("rsp_valid0_pulse", W'(rsp_valid0), 0);
        check("busy_after_resp", W'(busy), 0);
    endtask

    // Waits for the next ack and response, checking channel and data.
    task automatic serve(input bit ch, input logic [W-1:0] exp, input bit drop);
        int i;
        i = 0;
        while (!(ack0 || ack1) && i < 50) begin tick(); i++; end
        check("ack_seen", W'(ack0 || ack1), 1);
        check("ack_channel", W'(ack1), W'(ch));
        if (drop) begin
            if (ch) req1 = 1'b0;
            else    req0 = 1'b0;
        end
        i = 0;
        while (!(rsp_valid0 || rsp_valid1) && i < 300) begin tick(); i++; end
        check("rsp_seen", W'(rsp_valid0 || rsp_valid1), 1);
        check("rsp_channel", W'(rsp_valid1), W'(ch));
        check("rsp_data", ch ? rsp_data1 : rsp_data0, exp);
    endtask

    initial begin
        int r0;
        // Reset values
        tick(); tick();
        check("rst_ack0", W'(ack0), 0);
        check("rst_busy", W'(busy), 0);
        check("rst_grant_id", W'(grant_id), 1);
        check("rst_eng_reset", W'(eng_reset), 1);
        check("rst_eng_start", W'(eng_start), 0);
        check("rst_rsp_data0", rsp_data0, 0);
        check("rst_eng_message", eng_message, 0);
        check("rst_timeout_err", W'(timeout_err), 0);
        reset = 1'b0;
        tick();
        check("eng_reset_released", W'(eng_reset), 0);

        // Single job: 5^3 mod 33 = 26
        job0(5, 3, 33, 26);
        check("ch1_no_rsp", W'(n_rsp1), 0);
        check("ch1_data_untouched", rsp_data1, 0);
        check("ch1_no_ack", W'(n_ack1), 0);

        // Tie: ch0 wins after grant to ch0? last_grant is 0 now, so re-reset for a clean tie
        reset = 1'b1; tick(); reset = 1'b0; tick();
        msg0 = 5;  key0 = 3; n0 = 33;
        msg1 = 26; key1 = 7; n1 = 33;        // 26^7 mod 33 = 5
        req0 = 1'b1; req1 = 1'b1;
        tick();
        serve(1'b0, 26, 1'b1);
        tick();
        check("tie_idle_gap", W'(busy), 0);
        check("tie_no_ack1_yet", W'(ack1), 0);
        tick();
        check("tie_ack1_next", W'(ack1), 1);
        serve(1'b1, 5, 1'b1);
        tick();

        // Fairness with both held high
        req0 = 1'b1; req1 = 1'b1;
        tick();
        serve(1'b0, 26, 1'b0);
        serve(1'b1, 5, 1'b0);
        serve(1'b0, 26, 1'b1);
        serve(1'b1, 5, 1'b1);
        tick(); tick();
        check("fair_idle", W'(busy), 0);

        // Stale done: 7^3 mod 33 = 13
        check("stale_done_held", W'(eng_done), 1);
        job0(7, 3, 33, 13);

        // Reset mid-WAIT
        r0 = n_rsp0;
        req0 = 1'b1; msg0 = 2; key0 = 5; n0 = 33;
        tick();
        req0 = 1'b0;
        tick(); tick(); tick();
        check("midwait_busy", W'(busy), 1);
        reset = 1'b1;
        tick();
        check("midrst_busy", W'(busy), 0);
        check("midrst_eng_reset", W'(eng_reset), 1);
        check("midrst_rsp_valid0", W'(rsp_valid0), 0);
        check("midrst_rsp_data0", rsp_data0, 0);
        reset = 1'b0;
        for (int i = 0; i < 60; i++) tick();
        check("aborted_no_rsp", W'(n_rsp0), W'(r0));
        job0(2, 5, 33, 32);                  // 2^5 mod 33 = 32

`ifdef RSA_ARB_TIMEOUT_EN
        eng_hang = 1'b1;
        req0 = 1'b1; msg0 = 5; key0 = 3; n0 = 33;
        tick();
        req0 = 1'b0;
        tick();
        check("to_launch", W'(eng_start), 1);
        tick();                              // first WAIT cycle
        r0 = n_rsp0;
        for (int k = 1; k < 16; k++) tick();
        check("to_no_early_rsp", W'(n_rsp0), W'(r0));
        tick();
        check("to_rsp_valid0", W'(rsp_valid0), 1);
        check("to_timeout_err", W'(timeout_err), 1);
        check("to_rsp_data0", rsp_data0, 0);
        tick();
        check("to_err_pulse", W'(timeout_err), 0);
        check("total_ack0", W'(n_ack0), 8);
        check("total_rsp0", W'(n_rsp0), 7);
`else
        check("total_ack0", W'(n_ack0), 7);
        check("total_rsp0", W'(n_rsp0), 6);
`endif
        check("total_ack1", W'(n_ack1), 3);
        check("total_rsp1", W'(n_rsp1), 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
